xbar_slave_arbiter: RTL and testbench
=====================================

# xbar_slave_arbiter

Per-slave round-robin arbiter for the crossbar: one instance sits in front of each slave port and decides which master's request is forwarded. It holds a grant until the slave acknowledges, enforces fairness with a rotating priority pointer, and releases hung transactions with a watchdog. It flags each watchdog release and keeps a saturating error count.

## Interface
- NUM_M, 2, number of masters competing for this slave (2..8)
- TIMEOUT, 255, maximum grant length in cycles; 0 disables the watchdog
- IDX_W, $clog2(NUM_M) (min 1), width of the granted-master index
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- req  in  NUM_M  per-master request already decoded for this slave (req_i & address-select)
- slv_ack  in  1  slave completion strobe, one cycle
- gnt  out  NUM_M  one-hot grant, all-zero when idle
- gnt_valid  out  1  OR of gnt
- gnt_idx  out  IDX_W  binary index of the granted master, holds last value when idle
- timeout_err  out  1  one-cycle pulse on watchdog release
- err_count  out  8  saturating count of watchdog releases

## Operation
- States: IDLE, GRANT. Reset: state IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout_err=0, err_count=0, pointer last=NUM_M-1, so master 0 has top priority after reset.
- IDLE: if any req bit is high, pick the first set bit searching last+1, last+2, … mod NUM_M. Register gnt/gnt_idx, clear the watchdog counter, go to GRANT. If no req bit is high, stay in IDLE.
- GRANT: gnt is held constant regardless of req. A master dropping req does not release the grant; only ack or timeout releases it.
  - slv_ack=1: go to IDLE, gnt=0, last=gnt_idx.
  - Else if TIMEOUT≠0 and cnt==TIMEOUT-1: go to IDLE, gnt=0, last=gnt_idx, pulse timeout_err, err_count+1 saturating at 255.
  - Else cnt+1.
- Ack and timeout in the same cycle: ack wins; no error.
- slv_ack while in IDLE: ignored, no state change.
- Watchdog counter width is clog2(TIMEOUT+1); it never wraps because release happens at TIMEOUT-1.

## Timing
- Arbitration latency: req sampled high at edge t gives gnt high after edge t. gnt is registered output only; no combinational path from req to gnt.
- Release: slv_ack sampled high at edge k gives gnt low after edge k.
- There is at least one idle cycle between consecutive grants (the IDLE re-arbitration cycle).
- Grant length with no ack is exactly TIMEOUT cycles.
- timeout_err is high for exactly the one cycle following the release edge, coincident with the first idle cycle.
- Asynchronous reset mid-GRANT: gnt drops immediately, pointer returns to NUM_M-1, and err_count clears.

## Structure
- Shared package xbar_pkg: state enum (IDLE, GRANT), an err-count width constant (8), and a helper for the one-hot-to-index conversion, all shared with the crossbar top.
- Sub-module rr_picker: combinational, inputs req and last, outputs one-hot winner and index. It is reused by the response-path mux.
- The crossbar top instantiates one xbar_slave_arbiter per slave and steers address/cmd/wdata with gnt_idx.

## Test plan
- Reset, then req=2'b01 at edge 1 → gnt=2'b01 after edge 1; slv_ack at edge 4 → gnt=0 after edge 4; gnt_idx stays 0.
- req=2'b11 held, slave acks 3 cycles after each grant → grants alternate 01,10,01,10 with one idle cycle between them; master 0 wins first.
- TIMEOUT=8, req=2'b10, no ack → gnt=2'b10 for exactly 8 cycles, then timeout_err is a single pulse and err_count=1; next grant goes to master 0 if it is requesting.
- slv_ack and timeout on the same edge (ack at cycle TIMEOUT-1) → release with no timeout_err and err_count unchanged.
- NUM_M=4, req=4'b1111, 300 forced timeouts with TIMEOUT=2 → err_count saturates at 255 and grant order is 0,1,2,3 repeating.
- Reset asserted mid-GRANT, then req=4'b0110 → gnt clears immediately; after reset release master 1 wins first (last=3).

Source files
------------

// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Definitions shared by the crossbar top, the per-slave arbiters and the
// response-path mux:
//   arb_state_t    - arbiter FSM state (IDLE, GRANT)
//   ERR_W          - width of the saturating watchdog error counter
//   MAX_M          - largest number of masters the crossbar supports
//   onehot_to_idx  - one-hot grant vector to binary master index
// ---------------------------------------------------------------------------
package xbar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ERR_W = 8;
  localparam int MAX_M = 8;

  // OR-reduction encoder: exact for one-hot input, zero for all-zero input.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_M-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// ---------------------------------------------------------------------------
// xbar_slave_arbiter_if
// Request/grant bundle between the masters competing for one slave port and
// that slave's arbiter.
//   req          - per-master request, already decoded for this slave
//   slv_ack      - one-cycle completion strobe from the slave
//   gnt          - one-hot grant (all-zero when idle)
//   gnt_valid    - OR of gnt
//   gnt_idx      - binary index of the granted master
//   timeout_err  - one-cycle pulse on a watchdog release
//   err_count    - saturating count of watchdog releases
// Modports:
//   master - requester side (drives req and slv_ack)
//   slave  - arbiter side (drives the grant and status outputs)
// ---------------------------------------------------------------------------
interface xbar_slave_arbiter_if
  import xbar_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) ();

  logic [NUM_M-1:0] req;
  logic             slv_ack;
  logic [NUM_M-1:0] gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             timeout_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output req, slv_ack,
    input  gnt, gnt_valid, gnt_idx, timeout_err, err_count
  );

  modport slave (
    input  req, slv_ack,
    output gnt, gnt_valid, gnt_idx, timeout_err, err_count
  );

endinterface

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req starting at last+1,
// wrapping modulo NUM_M, and returns the first requesting master.
//   req     in  NUM_M  request vector
//   last    in  IDX_W  index of the most recently served master
//   winner  out NUM_M  one-hot winner, all-zero when no request
//   idx     out IDX_W  binary index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_picker
  import xbar_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_M-1:0] winner,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_M - 1);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = last;
    // Visit last+1 .. last+NUM_M; the final step revisits 'last' itself so
    // a lone requester that was just served still wins.
    for (int k = 0; k < NUM_M; k++) begin
      cand = (cand == TOP_IDX) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
      end
    end
    idx = IDX_W'(onehot_to_idx(MAX_M'(winner)));
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_slave_arbiter
// Per-slave round-robin arbiter. A grant is held until the slave acks or the
// watchdog expires after TIMEOUT cycles; each release rotates priority past
// the served master. Every grant is followed by one idle re-arbitration
// cycle. Outputs are registered; there is no combinational req->gnt path.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of xbar_slave_arbiter_if (req/slv_ack in,
//          gnt/gnt_valid/gnt_idx/timeout_err/err_count out)
// Parameters: NUM_M (2..8), TIMEOUT (0 disables watchdog), IDX_W.
// ---------------------------------------------------------------------------
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  parameter int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  xbar_slave_arbiter_if.slave  bus
);

  // Counter only has to reach TIMEOUT-1, so it can never wrap.
  localparam int               CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int               CNT_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit               WDOG_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(CNT_LAST);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_M - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  arb_state_t       state_reg;
  logic [NUM_M-1:0] gnt_reg;
  logic [IDX_W-1:0] gnt_idx_reg;
  logic [IDX_W-1:0] last_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_err_reg;
  logic [ERR_W-1:0] err_count_reg;

  logic [NUM_M-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;

  rr_picker #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (bus.req),
    .last   (last_reg),
    .winner (pick_gnt),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      gnt_idx_reg     <= '0;
      last_reg        <= LAST_INIT;
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      timeout_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // slv_ack is deliberately ignored here.
          if (|bus.req) begin
            gnt_reg     <= pick_gnt;
            gnt_idx_reg <= pick_idx;
            cnt_reg     <= '0;
            state_reg   <= GRANT;
          end
        end
        GRANT: begin
          // Grant is frozen against req changes; ack takes precedence over
          // a watchdog expiry on the same edge.
          if (bus.slv_ack) begin
            gnt_reg   <= '0;
            last_reg  <= gnt_idx_reg;
            state_reg <= IDLE;
          end else if (WDOG_EN && (cnt_reg == CNT_END)) begin
            gnt_reg         <= '0;
            last_reg        <= gnt_idx_reg;
            state_reg       <= IDLE;
            timeout_err_reg <= 1'b1;
            if (err_count_reg != ERR_MAX) begin
              err_count_reg <= err_count_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.gnt_valid   = |gnt_reg;
  assign bus.gnt_idx     = gnt_idx_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.err_count   = err_count_reg;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbar_slave_arbiter
// Three arbiter instances sharing clock and reset:
//   dut_a  NUM_M=2 TIMEOUT=255  basic grant/ack and round-robin alternation
//   dut_b  NUM_M=2 TIMEOUT=8    watchdog release, ack/timeout collision
//   dut_c  NUM_M=4 TIMEOUT=2    error-count saturation, reset mid-grant
// ---------------------------------------------------------------------------
module tb_xbar_slave_arbiter;
  import xbar_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xbar_slave_arbiter_if #(.NUM_M(2)) bus_a ();
  xbar_slave_arbiter_if #(.NUM_M(2)) bus_b ();
  xbar_slave_arbiter_if #(.NUM_M(4)) bus_c ();

  xbar_slave_arbiter #(.NUM_M(2), .TIMEOUT(255)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  xbar_slave_arbiter #(.NUM_M(2), .TIMEOUT(8))   dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  xbar_slave_arbiter #(.NUM_M(4), .TIMEOUT(2))   dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    check("rst_gnt_a",   32'(bus_a.gnt), 32'd0);
    check("rst_valid_a", 32'(bus_a.gnt_valid), 32'd0);
    check("rst_idx_a",   32'(bus_a.gnt_idx), 32'd0);
    check("rst_terr_a",  32'(bus_a.timeout_err), 32'd0);
    check("rst_err_a",   32'(bus_a.err_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic       pre_rst;
    logic [1:0] req;
    logic       ack;
    logic [1:0] gnt;
    logic       idx;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [3:0] exp_oh;
    int         exp_err;

    bus_a.req = '0; bus_a.slv_ack = 1'b0;
    bus_b.req = '0; bus_b.slv_ack = 1'b0;
    bus_c.req = '0; bus_c.slv_ack = 1'b0;

    // Phase 1: single requester, hold past req drop, ack release, idle ack.
    // Phase 2 (after reset): both request, ack 3 cycles after each grant.
    vecs[0]  = '{1'b1, 2'b01, 1'b0, 2'b01, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
    vecs[6]  = '{1'b1, 2'b11, 1'b0, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1};
    vecs[13] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};
    vecs[16] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};
    vecs[17] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0};
    vecs[18] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1};

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].pre_rst) begin
        bus_a.req = '0;
        bus_a.slv_ack = 1'b0;
        pulse_reset();
      end
      bus_a.req     = vecs[i].req;
      bus_a.slv_ack = vecs[i].ack;
      tick();
      $display("vec %0d req=%b ack=%b gnt=%b idx=%0d", i, vecs[i].req, vecs[i].ack,
               bus_a.gnt, bus_a.gnt_idx);
      check("a_gnt",   32'(bus_a.gnt), 32'(vecs[i].gnt));
      check("a_valid", 32'(bus_a.gnt_valid), 32'(|vecs[i].gnt));
      check("a_idx",   32'(bus_a.gnt_idx), 32'(vecs[i].idx));
      check("a_terr",  32'(bus_a.timeout_err), 32'd0);
    end
    bus_a.req = '0;
    bus_a.slv_ack = 1'b0;

    // Watchdog: master 1 alone, no ack -> exactly 8 grant cycles.
    pulse_reset();
    bus_b.req = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("b_hold_gnt",  32'(bus_b.gnt), 32'h2);
      check("b_hold_terr", 32'(bus_b.timeout_err), 32'd0);
    end
    tick();
    $display("b timeout release gnt=%b terr=%b err=%0d", bus_b.gnt, bus_b.timeout_err, bus_b.err_count);
    check("b_rel_gnt",  32'(bus_b.gnt), 32'd0);
    check("b_rel_terr", 32'(bus_b.timeout_err), 32'd1);
    check("b_rel_err",  32'(bus_b.err_count), 32'd1);
    bus_b.req = 2'b11;
    tick();
    check("b_next_gnt",  32'(bus_b.gnt), 32'h1);
    check("b_next_terr", 32'(bus_b.timeout_err), 32'd0);
    // Ack lands on the same edge the watchdog would fire.
    for (int c = 0; c < 7; c++) begin
      tick();
      check("b_coll_hold", 32'(bus_b.gnt), 32'h1);
    end
    bus_b.slv_ack = 1'b1;
    tick();
    $display("b ack+timeout gnt=%b terr=%b err=%0d", bus_b.gnt, bus_b.timeout_err, bus_b.err_count);
    check("b_coll_gnt",  32'(bus_b.gnt), 32'd0);
    check("b_coll_terr", 32'(bus_b.timeout_err), 32'd0);
    check("b_coll_err",  32'(bus_b.err_count), 32'd1);
    bus_b.slv_ack = 1'b0;
    bus_b.req = '0;
    tick();
    check("b_after_terr", 32'(bus_b.timeout_err), 32'd0);
    check("b_after_gnt",  32'(bus_b.gnt), 32'd0);

    // Saturation: four masters, every grant forced out by TIMEOUT=2.
    pulse_reset();
    bus_c.req = 4'b1111;
    for (int k = 0; k < 300; k++) begin
      exp_oh  = 4'(4'b0001 << (k % 4));
      exp_err = (k + 1 > 255) ? 255 : k + 1;
      tick();
      check("c_gnt",  32'(bus_c.gnt), 32'(exp_oh));
      check("c_idx",  32'(bus_c.gnt_idx), 32'(k % 4));
      check("c_terr_low", 32'(bus_c.timeout_err), 32'd0);
      tick();
      check("c_gnt2", 32'(bus_c.gnt), 32'(exp_oh));
      tick();
      check("c_rel_gnt",  32'(bus_c.gnt), 32'd0);
      check("c_rel_terr", 32'(bus_c.timeout_err), 32'd1);
      check("c_err",      32'(bus_c.err_count), 32'(exp_err));
    end
    $display("c after 300 timeouts err=%0d", bus_c.err_count);

    // Reset in the middle of a grant.
    tick();
    check("c_pre_rst_gnt", 32'(bus_c.gnt), 32'h1);
    #2;
    bus_c.req = 4'b0110;
    reset = 1'b1;
    #1;
    $display("c mid-grant reset gnt=%b err=%0d", bus_c.gnt, bus_c.err_count);
    check("c_rst_gnt",   32'(bus_c.gnt), 32'd0);
    check("c_rst_valid", 32'(bus_c.gnt_valid), 32'd0);
    check("c_rst_err",   32'(bus_c.err_count), 32'd0);
    check("c_rst_idx",   32'(bus_c.gnt_idx), 32'd0);
    #3;
    reset = 1'b0;
    tick();
    $display("c post-reset gnt=%b idx=%0d", bus_c.gnt, bus_c.gnt_idx);
    check("c_post_gnt", 32'(bus_c.gnt), 32'h2);
    check("c_post_idx", 32'(bus_c.gnt_idx), 32'd1);
    bus_c.req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
